inst_mem_ctrl: RTL and testbench

Parametrised, loadable instruction memory for the RISC-V core, successor to the fixed 64×32 asynchronous-read instruction ROM. It sits between the fetch stage and an external boot loader. It provides a synchronous, handshaked fetch port with alignment and range checking, and a streaming load port so the program can be written at run time instead of only from a preload file.

---
 rtl/inst_mem_pkg.sv | 22 ++
 rtl/inst_mem_array.sv | 38 +++
 rtl/inst_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_inst_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared types and constants for the loadable instruction memory.
//   fault_e  - response fault code carried on rsp_fault
//   state_e  - controller FSM state (RUN / DRAIN / LOAD)
//   NOP_INSTR - addi x0,x0,0, returned in place of an instruction on any fault
package inst_mem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10,
        FAULT_PARITY   = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOAD
    } state_e;

endpackage

// File: rtl/inst_mem_array.sv
// inst_mem_array: storage only. One synchronous write port, one synchronous
// read port with a registered read word. Contents are not reset.
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write word index
//   wdata_i  - write word (WIDTH bits, includes parity bit when enabled)
//   re_i     - read enable; rdata_o updates after the edge
//   raddr_i  - read word index
//   rdata_o  - registered read word, held while re_i is low
module inst_mem_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: loadable instruction memory with a handshaked fetch port
// (alignment and range checks, one-cycle latency) and a streaming load port.
// Optional feature macro: INST_MEM_PARITY_EN (stores even parity per word and
// reports fault 11 on a parity mismatch at read).
//   clk, rst              - clock, asynchronous active-high reset
//   boot_load             - level request to enter load mode
//   ld_valid/ld_ready     - load word handshake; ld_data word, ld_last final word
//   load_done             - one-cycle pulse in the first RUN cycle after a load
//   req_valid/req_ready   - fetch request handshake; req_addr byte address
//   rsp_valid/rsp_ready   - response handshake; rsp_instr word, rsp_fault code
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 64,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [DATA_W-1:0] FAULT_INSTR = DATA_W'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_load,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              load_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [1:0]        rsp_fault
);

    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WORD_W = ADDR_W - 2;
`ifdef INST_MEM_PARITY_EN
    localparam int unsigned MEM_W  = DATA_W + 1;
`else
    localparam int unsigned MEM_W  = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              load_done_q;
    logic              rsp_valid_q;
    logic              rsp_mem_q;      // response word comes from the array
    fault_e            rsp_fault_q;

    logic              misalign, out_of_range;
    logic              fetch_acc, rd_en;
    logic              ld_acc, ld_final;
    logic              par_err;
    logic [MEM_W-1:0]  mem_wdata, mem_rdata;
    logic [DATA_W-1:0] mem_word;

    assign misalign     = |req_addr[1:0];
    assign out_of_range = req_addr[ADDR_W-1:2] >= WORD_W'(DEPTH);
    assign fetch_acc    = req_valid & req_ready;
    assign rd_en        = fetch_acc & ~misalign & ~out_of_range;
    assign ld_acc       = ld_valid & ld_ready;
    // Load stops at the top word even without ld_last, so the counter never wraps.
    assign ld_final     = ld_acc & (ld_last | (cnt_q == AW'(DEPTH - 1)));

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (boot_load) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!boot_load)        state_d = ST_RUN;
                else if (!rsp_valid_q) state_d = ST_LOAD;
            end
            ST_LOAD:  if (ld_final) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ld_ready  = (state_q == ST_LOAD);
        req_ready = (state_q == ST_RUN) & ~boot_load & (~rsp_valid_q | rsp_ready);
    end

    // Load word counter; held at zero outside LOAD so every entry starts at word 0.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_LOAD) begin
            cnt_d = '0;
        end else if (ld_acc) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            load_done_q <= ld_final;
        end
    end

    // Response register. Fault words never touch the array; rsp_mem_q selects
    // between the array's registered read word and FAULT_INSTR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_mem_q   <= 1'b0;
            rsp_fault_q <= FAULT_NONE;
        end else if (fetch_acc) begin
            rsp_valid_q <= 1'b1;
            rsp_mem_q   <= rd_en;
            rsp_fault_q <= misalign     ? FAULT_MISALIGN :
                           out_of_range ? FAULT_RANGE    : FAULT_NONE;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef INST_MEM_PARITY_EN
    assign mem_wdata = {^ld_data, ld_data};
    assign mem_word  = mem_rdata[DATA_W-1:0];
    assign par_err   = rsp_mem_q & (^mem_rdata);
`else
    assign mem_wdata = ld_data;
    assign mem_word  = mem_rdata;
    assign par_err   = 1'b0;
`endif

    always_comb begin
        rsp_instr = FAULT_INSTR;
        rsp_fault = rsp_fault_q;
        if (par_err) begin
            rsp_fault = FAULT_PARITY;
        end else if (rsp_mem_q) begin
            rsp_instr = mem_word;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign load_done = load_done_q;

    inst_mem_array #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (ld_acc),
        .waddr_i (cnt_q),
        .wdata_i (mem_wdata),
        .re_i    (rd_en),
        .raddr_i (req_addr[AW+1:2]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: self-checking bench for inst_mem_ctrl (default parameters).
// Reference model: a word array written by the load stream plus a single
// pending-response slot; expected fetch results come from the address rules.
// With INST_MEM_PARITY_EN defined, a stored bit is flipped to exercise fault 11.
module tb_inst_mem_ctrl;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_load, ld_valid, ld_ready, ld_last, load_done;
    logic [31:0] ld_data;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_addr, rsp_instr;
    logic [1:0]  rsp_fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_bad [DEPTH];
    logic [31:0] ld_words [$];
    bit          exp_valid;
    logic [31:0] exp_instr;
    logic [1:0]  exp_fault;

    always #5 clk = ~clk;

    inst_mem_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .boot_load (boot_load),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .load_done (load_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_fetch(input logic [31:0] a, output logic [31:0] ins,
                                      output logic [1:0] f);
        logic [31:0] w;
        w = a >> 2;
        if (a[1:0] != 2'b00) begin
            f = 2'd1; ins = NOP;
        end else if (w >= DEPTH) begin
            f = 2'd2; ins = NOP;
        end else if (ref_bad[w[5:0]]) begin
            f = 2'd3; ins = NOP;
        end else begin
            f = 2'd0; ins = ref_mem[w[5:0]];
        end
    endfunction

    // One RUN-mode cycle: drive the fetch side, compare against the model, advance.
    task automatic cycle(input bit v, input logic [31:0] a, input bit rr);
        bit exp_rdy;
        req_valid = v; req_addr = a; rsp_ready = rr;
        #1;
        exp_rdy = !exp_valid || rr;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("rsp_instr", rsp_instr, exp_instr);
            check_eq("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
        end
        if (v && exp_rdy) begin
            exp_valid = 1'b1;
            ref_fetch(a, exp_instr, exp_fault);
        end else if (rr) begin
            exp_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Streams ld_words; the final word is ld_last when use_last is set.
    task automatic do_load(input bit use_last);
        int  cyc;
        int  idx;
        bit  done;
        int  n;
        n = ld_words.size();
        req_valid = 1'b0; rsp_ready = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
        boot_load = 1'b1;
        cyc = 0;
        @(posedge clk); #1;
        while (!ld_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("ld_enter", 32'(ld_ready), 32'd1);
        idx = 0; done = 1'b0;
        for (int k = 0; k < n; k++) begin
            ld_valid = 1'b1;
            ld_data  = ld_words[k];
            ld_last  = use_last && (k == n - 1);
            if (!done) begin
                if (ld_last || idx == DEPTH - 1) boot_load = 1'b0;
                #1;
                check_eq("ld_ready", 32'(ld_ready), 32'd1);
                ref_mem[idx] = ld_words[k];
                ref_bad[idx] = 1'b0;
            end else begin
                #1;
                check_eq("ld_ready_after", 32'(ld_ready), 32'd0);
            end
            @(posedge clk); #1;
            if (!done) begin
                if (ld_last || idx == DEPTH - 1) begin
                    done = 1'b1;
                    check_eq("load_done", 32'(load_done), 32'd1);
                    check_eq("ld_ready_exit", 32'(ld_ready), 32'd0);
                end else begin
                    check_eq("load_done_mid", 32'(load_done), 32'd0);
                end
                idx++;
            end else begin
                check_eq("load_done_once", 32'(load_done), 32'd0);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0; boot_load = 1'b0;
        @(posedge clk); #1;
        check_eq("load_done_pulse", 32'(load_done), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
        check_eq("rst_load_done", 32'(load_done), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_instr", rsp_instr, NOP);
        check_eq("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) ref_bad[i] = 1'b0;
        rst = 1'b1; boot_load = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        exp_valid = 1'b0; exp_instr = NOP; exp_fault = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        // Three-word program, then back-to-back fetches
        ld_words = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        do_load(1'b1);
        cycle(1'b1, 32'h0, 1'b1);
        cycle(1'b1, 32'h4, 1'b1);
        cycle(1'b1, 32'h8, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

        // Misaligned and out-of-range
        cycle(1'b1, 32'h6, 1'b1);
        cycle(1'b1, 32'h100, 1'b1);
        cycle(1'b1, 32'h103, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

        // Backpressure: 4 stalled cycles, then the release cycle accepts
        cycle(1'b1, 32'h4, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h8, 1'b0);
        cycle(1'b1, 32'h8, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

        // 70-word stream without ld_last stops at the top word
        ld_words.delete();
        for (int i = 0; i < 70; i++) ld_words.push_back($urandom);
        do_load(1'b0);
        cycle(1'b1, 32'(4 * (DEPTH - 1)), 1'b1);
        cycle(1'b1, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

        // Randomized fetch traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                2:       a = $urandom;
                default: a = 32'($urandom_range(DEPTH * 4 - 8, DEPTH * 4 + 8));
            endcase
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0);
        end
        cycle(1'b0, 32'h0, 1'b1);

        // boot_load while a response is stalled: stays in DRAIN until consumed
        cycle(1'b1, 32'h10, 1'b0);
        boot_load = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("drain_ld_ready", 32'(ld_ready), 32'd0);
            check_eq("drain_req_ready", 32'(req_ready), 32'd0);
            check_eq("drain_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("drain_rsp_instr", rsp_instr, exp_instr);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        check_eq("drain_consumed", 32'(rsp_valid), 32'd0);
        check_eq("drain_still", 32'(ld_ready), 32'd0);
        @(posedge clk); #1;
        check_eq("drain_to_load", 32'(ld_ready), 32'd1);

        // Reset in the middle of a load keeps the words already written
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ref_mem[i] = ld_data;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        check_eq("midload_ld_ready", 32'(ld_ready), 32'd1);
        rst = 1'b1; boot_load = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 32'h0, 1'b1);
        cycle(1'b1, 32'h4, 1'b1);
        cycle(1'b1, 32'h8, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

`ifdef INST_MEM_PARITY_EN
        ref_bad[5] = 1'b1;
        u_dut.u_array.mem_q[5][0] = ~u_dut.u_array.mem_q[5][0];
        cycle(1'b1, 32'd20, 1'b1);
        cycle(1'b1, 32'd24, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
